apb_master_bridge: RTL and testbench

- Synthesizable APB initiator that converts single-beat register commands into APB SETUP/ACCESS transfers on the timer's 8-bit APB bus.
- Replaces the behavioural CPU model so on-chip logic and the bench can program TDR (0x00), TCR (0x01) and TSR (0x02).
- Returns read data and an error/timeout status per command.

---
 rtl/apb_master_bridge.sv | 104 ++++++++++
 tb/tb_apb_master_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-beat command to APB SETUP/ACCESS initiator
// One command in flight; response reports read data, slave error and wait timeout.
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite <= cmd_write;
                        paddr  <= cmd_addr;
                        pwdata <= cmd_wdata;
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // pslverr and prdata only count on the cycle the slave says ready
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - scoreboard bench for apb_master_bridge with a timer-like APB slave
module tb_apb_master_bridge;

    localparam int TO = 16;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         lat;
        int         acc;
    } exp_t;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata = 8'h00;
    logic       pready = 1'b0;
    logic       pslverr = 1'b0;

    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Timer slave: TDR/TCR/TSR; TCR[0] runs a clk/16 down-counter reloaded from TDR, underflow sets TSR[1]
    int         cfg_wait = 0;
    bit         cfg_err = 1'b0;
    bit         cfg_hang = 1'b0;
    logic [7:0] tdr, tcr, tsr, tcnt;
    int         presc, wait_left;
    int         xfer_cnt = 0;

    always @(negedge pclk) begin
        if (preset) begin
            tdr = 0; tcr = 0; tsr = 0; tcnt = 0; presc = 0; wait_left = 0;
            pready = 0; pslverr = 0; prdata = 0;
        end else begin
            if (tcr[0]) begin
                presc++;
                if (presc == 16) begin
                    presc = 0;
                    if (tcnt == 0) begin tsr = tsr | 8'h02; tcnt = tdr; end
                    else tcnt = tcnt - 1;
                end
            end
            if (psel && !penable) begin
                wait_left = cfg_wait; pready = 0; pslverr = 0;
            end else if (psel && penable) begin
                if (cfg_hang || wait_left > 0) begin
                    pready = 0;
                    if (wait_left > 0) wait_left--;
                end else begin
                    pready = 1; pslverr = cfg_err; xfer_cnt++;
                    if (cfg_err) prdata = 8'hA5;
                    else if (pwrite) begin
                        prdata = 8'hC3;
                        case (paddr)
                            8'h00: tdr = pwdata;
                            8'h01: begin tcr = pwdata; tcnt = tdr; presc = 0; end
                            8'h02: tsr = pwdata;
                            default: ;
                        endcase
                    end else begin
                        case (paddr)
                            8'h00: prdata = tdr;
                            8'h01: prdata = tcr;
                            8'h02: prdata = tsr;
                            default: prdata = 8'h00;
                        endcase
                    end
                end
            end else begin
                pready = 0; pslverr = 0;
            end
        end
    end

    // Observation only: handshakes, APB phase counts, bus stability, responses
    int         hs_cnt = 0, setup_cnt = 0, access_cnt = 0, bus_changes = 0, rsp_cnt = 0;
    int         hs_cyc[256], obs_cyc[256];
    logic [7:0] obs_rdata[256];
    logic       obs_err[256], obs_to[256];
    logic       prev_psel = 1'b0;
    logic [16:0] prev_bus = '0;

    always @(negedge pclk) begin
        if (preset) begin
            prev_psel = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin hs_cyc[hs_cnt % 256] = cyc; hs_cnt++; end
            if (psel && !penable) setup_cnt++;
            if (psel && penable) access_cnt++;
            if (psel && prev_psel && ({paddr, pwrite, pwdata} !== prev_bus)) bus_changes++;
            if (rsp_valid) begin
                obs_rdata[rsp_cnt % 256] = rsp_rdata;
                obs_err[rsp_cnt % 256]   = rsp_err;
                obs_to[rsp_cnt % 256]    = rsp_timeout;
                obs_cyc[rsp_cnt % 256]   = cyc;
                rsp_cnt++;
            end
            prev_psel = psel;
            prev_bus  = {paddr, pwrite, pwdata};
        end
    end

    int   vectors = 0, miscompares = 0;
    exp_t sbq[$];

    task automatic do_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] er, input logic ee, input logic et,
                          input int lat, input int acc, input string tag);
        exp_t e;
        int hs0, r0, s0, a0, b0, n;
        e.rdata = er; e.err = ee; e.to = et; e.lat = lat; e.acc = acc;
        sbq.push_back(e);
        hs0 = hs_cnt; r0 = rsp_cnt; s0 = setup_cnt; a0 = access_cnt; b0 = bus_changes;
        @(posedge pclk); #1;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (hs_cnt == hs0 && n < 50) begin @(negedge pclk); #1; n++; end
        @(posedge pclk); #1;
        cmd_valid = 0;
        vectors++;
        if (hs_cnt == hs0) begin
            miscompares++;
            $display("FAIL %s accept: no handshake within %0d cycles", tag, n);
            void'(sbq.pop_front());
            return;
        end
        n = 0;
        while (rsp_cnt == r0 && n < 200) begin @(negedge pclk); #1; n++; end
        vectors++;
        if (rsp_cnt == r0) begin
            miscompares++;
            $display("FAIL %s rsp_wait: no rsp_valid within %0d cycles", tag, n);
            void'(sbq.pop_front());
            return;
        end
        e = sbq.pop_front();
        vectors++;
        if (obs_rdata[r0 % 256] !== e.rdata) begin miscompares++;
            $display("FAIL %s rsp_rdata: got %h expected %h", tag, obs_rdata[r0 % 256], e.rdata); end
        vectors++;
        if (obs_err[r0 % 256] !== e.err) begin miscompares++;
            $display("FAIL %s rsp_err: got %b expected %b", tag, obs_err[r0 % 256], e.err); end
        vectors++;
        if (obs_to[r0 % 256] !== e.to) begin miscompares++;
            $display("FAIL %s rsp_timeout: got %b expected %b", tag, obs_to[r0 % 256], e.to); end
        vectors++;
        if (obs_cyc[r0 % 256] - hs_cyc[hs0 % 256] != e.lat) begin miscompares++;
            $display("FAIL %s latency: got %0d expected %0d", tag, obs_cyc[r0 % 256] - hs_cyc[hs0 % 256], e.lat); end
        vectors++;
        if (setup_cnt - s0 != 1) begin miscompares++;
            $display("FAIL %s setup_cycles: got %0d expected 1", tag, setup_cnt - s0); end
        vectors++;
        if (access_cnt - a0 != e.acc) begin miscompares++;
            $display("FAIL %s access_cycles: got %0d expected %0d", tag, access_cnt - a0, e.acc); end
        vectors++;
        if (bus_changes != b0) begin miscompares++;
            $display("FAIL %s bus_stable: got %0d changes expected 0", tag, bus_changes - b0); end
        vectors++;
        if (psel !== 1'b0 || penable !== 1'b0) begin miscompares++;
            $display("FAIL %s psel_after: got psel=%b penable=%b expected 0/0", tag, psel, penable); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge pclk);
        #1;
        vectors++;
        if ({psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got psel=%b pen=%b pw=%b pa=%h pd=%h rv=%b rd=%h re=%b rt=%b expected all 0",
                     psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
        preset = 0;
        @(negedge pclk); #1;
        vectors++;
        if (cmd_ready !== 1'b1 || psel !== 1'b0) begin miscompares++;
            $display("FAIL reset_release: got cmd_ready=%b psel=%b expected 1/0", cmd_ready, psel); end
    endtask

    task automatic test_read_wait();
        do_cmd(1, 8'h02, 8'h02, 8'h00, 0, 0, 3, 1, "tsr_preload");
        cfg_wait = 3;
        do_cmd(0, 8'h02, 8'h00, 8'h02, 0, 0, 6, 4, "read_wait");
        cfg_wait = 0;
        do_cmd(1, 8'h02, 8'h00, 8'h00, 0, 0, 3, 1, "tsr_clear");
    endtask

    task automatic test_timer_write();
        do_cmd(1, 8'h00, 8'hFF, 8'h00, 0, 0, 3, 1, "wr_tdr");
        do_cmd(1, 8'h01, 8'h83, 8'h00, 0, 0, 3, 1, "wr_tcr_83");
        do_cmd(1, 8'h01, 8'h33, 8'h00, 0, 0, 3, 1, "wr_tcr_33");
        vectors++;
        if (tdr !== 8'hFF) begin miscompares++; $display("FAIL timer_tdr: got %h expected ff", tdr); end
        vectors++;
        if (tcr !== 8'h33) begin miscompares++; $display("FAIL timer_tcr: got %h expected 33", tcr); end
    endtask

    task automatic test_timer_flow();
        do_cmd(1, 8'h01, 8'h33, 8'h00, 0, 0, 3, 1, "flow_tcr");
        repeat (1000) @(posedge pclk);
        do_cmd(0, 8'h02, 8'h00, 8'h00, 0, 0, 3, 1, "flow_tsr_early");
        repeat (4096) @(posedge pclk);
        do_cmd(0, 8'h02, 8'h00, 8'h02, 0, 0, 3, 1, "flow_tsr_underflow");
        do_cmd(1, 8'h02, 8'h00, 8'h00, 0, 0, 3, 1, "flow_tsr_clear");
        do_cmd(0, 8'h02, 8'h00, 8'h00, 0, 0, 3, 1, "flow_tsr_cleared");
    endtask

    task automatic test_slave_error();
        cfg_err = 1;
        do_cmd(0, 8'h00, 8'h00, 8'h00, 1, 0, 3, 1, "slverr_read");
        cfg_err = 0;
    endtask

    task automatic test_timeout();
        cfg_hang = 1;
        do_cmd(0, 8'h01, 8'h00, 8'h00, 1, 1, 2 + TO, TO, "timeout");
        cfg_hang = 0;
    endtask

    task automatic test_back_to_back();
        int hs0, x0, r0, hold, exp_hs;
        hold = 12;
        exp_hs = (hold + 3) / 4;
        hs0 = hs_cnt; x0 = xfer_cnt; r0 = rsp_cnt;
        @(posedge pclk); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h00; cmd_wdata = 8'h5A;
        repeat (hold) @(posedge pclk);
        #1 cmd_valid = 0;
        repeat (10) @(negedge pclk);
        #1;
        vectors++;
        if (hs_cnt - hs0 != exp_hs) begin miscompares++;
            $display("FAIL bp_handshakes: got %0d expected %0d", hs_cnt - hs0, exp_hs); end
        vectors++;
        if (xfer_cnt - x0 != exp_hs) begin miscompares++;
            $display("FAIL bp_transfers: got %0d expected %0d", xfer_cnt - x0, exp_hs); end
        vectors++;
        if (rsp_cnt - r0 != exp_hs) begin miscompares++;
            $display("FAIL bp_responses: got %0d expected %0d", rsp_cnt - r0, exp_hs); end
        for (int i = 1; i < exp_hs && i < hs_cnt - hs0; i++) begin
            vectors++;
            if (hs_cyc[(hs0 + i) % 256] - hs_cyc[(hs0 + i - 1) % 256] != 4) begin miscompares++;
                $display("FAIL bp_spacing: got %0d expected 4", hs_cyc[(hs0 + i) % 256] - hs_cyc[(hs0 + i - 1) % 256]); end
        end
        for (int i = 0; i < rsp_cnt - r0; i++) begin
            vectors++;
            if (obs_err[(r0 + i) % 256] !== 1'b0 || obs_rdata[(r0 + i) % 256] !== 8'h00) begin miscompares++;
                $display("FAIL bp_rsp: got err=%b rdata=%h expected 0/00", obs_err[(r0 + i) % 256], obs_rdata[(r0 + i) % 256]); end
        end
        vectors++;
        if (tdr !== 8'h5A) begin miscompares++; $display("FAIL bp_tdr: got %h expected 5a", tdr); end
    endtask

    task automatic test_reset_mid_access();
        int hs0, r0, n;
        hs0 = hs_cnt; r0 = rsp_cnt;
        cfg_hang = 1;
        @(posedge pclk); #1;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 8'h01;
        n = 0;
        while (hs_cnt == hs0 && n < 50) begin @(negedge pclk); #1; n++; end
        @(posedge pclk); #1;
        cmd_valid = 0;
        n = 0;
        while (penable !== 1'b1 && n < 20) begin @(negedge pclk); #1; n++; end
        vectors++;
        if (penable !== 1'b1) begin miscompares++;
            $display("FAIL rst_mid_reach_access: got penable=%b expected 1", penable); end
        #2 preset = 1;
        #1;
        vectors++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_mid_async: got psel=%b penable=%b rsp_valid=%b expected 0/0/0", psel, penable, rsp_valid); end
        @(negedge pclk); #1;
        preset = 0; cfg_hang = 0;
        @(negedge pclk); #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_mid_cmd_ready: got %b expected 1", cmd_ready); end
        repeat (20) @(negedge pclk);
        #1;
        vectors++;
        if (rsp_cnt != r0) begin miscompares++;
            $display("FAIL rst_mid_no_rsp: got %0d responses expected 0", rsp_cnt - r0); end
        vectors++;
        if (psel !== 1'b0) begin miscompares++;
            $display("FAIL rst_mid_idle: got psel=%b expected 0", psel); end
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_timer_write();
        test_timer_flow();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
